// File: rtl/fir_dout_fp16_packer.sv
// Converts the FIR 29-bit wide-float output word into IEEE FP16.
// Normalisation is serial (one shift per cycle) followed by one round-to-nearest-even cycle.
module fir_dout_fp16_packer #(
  parameter int MAN_W      = 22,
  parameter int EXP_W      = 6,
  parameter int EXP_OFFSET = 52
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MAN_W+EXP_W:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [15:0]                out_data,
  output logic                       out_ovf,
  output logic                       out_unf,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Shift from the input scaling to the FP16 biased exponent with the MSB at bit MAN_W-1.
  localparam int         EV_BIAS_I = EXP_OFFSET - (MAN_W - 1) - 15;
  localparam logic [8:0] EV_BIAS   = EV_BIAS_I[8:0];
  localparam logic [4:0] MAX_SHIFT = 5'(MAN_W - 1);

  logic [1:0]              state_r;
  logic                    sign_r;
  logic [MAN_W-1:0]        man_r;
  logic signed [8:0]       ev_r;
  logic [4:0]              cnt_r;
  logic [15:0]             out_data_r;
  logic                    out_ovf_r;
  logic                    out_unf_r;
  logic                    out_valid_r;
  logic                    accept_s;
  logic signed [8:0]       ev_init_s;

  // Returns {ovf, unf, fp16} for a normalised mantissa and its unbiased-to-FP16 exponent.
  function automatic logic [17:0] fp16_round(input logic              s,
                                             input logic signed [8:0] ev,
                                             input logic [MAN_W-1:0]  m);
    logic [9:0]        frac;
    logic              g;
    logic              st;
    logic [10:0]       sum;
    logic signed [8:0] ev_f;
    logic [17:0]       r;
    frac = m[MAN_W-2 -: 10];
    g    = m[MAN_W-12];
    st   = |m[MAN_W-13:0];
    sum  = {1'b0, frac} + {10'd0, (g & (st | frac[0]))};
    ev_f = ev + $signed({8'd0, sum[10]});
    if (m == {MAN_W{1'b0}}) begin
      r = {2'b00, s, 15'h0000};
    end else if (ev <= 9'sd0) begin
      r = {2'b01, s, 15'h0000};
    end else if (ev_f >= 9'sd31) begin
      r = {2'b10, s, 5'h1F, 10'h000};
    end else begin
      // A carry out of the fraction leaves sum[9:0] at zero, which is the wanted mantissa.
      r = {2'b00, s, ev_f[4:0], sum[9:0]};
    end
    return r;
  endfunction

  assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_OUT) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign ev_init_s = $signed({{(9-EXP_W){1'b0}}, in_data[MAN_W+EXP_W-1:MAN_W]}) - $signed(EV_BIAS);

  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign out_unf   = out_unf_r;
  assign out_valid = out_valid_r;

  // Handshake, normalise and round sequencing with all result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sign_r      <= 1'b0;
      man_r       <= {MAN_W{1'b0}};
      ev_r        <= 9'sd0;
      cnt_r       <= 5'd0;
      out_data_r  <= 16'h0000;
      out_ovf_r   <= 1'b0;
      out_unf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OUT: begin
          if (accept_s) begin
            sign_r      <= in_data[MAN_W+EXP_W];
            man_r       <= in_data[MAN_W-1:0];
            ev_r        <= ev_init_s;
            cnt_r       <= 5'd0;
            out_valid_r <= 1'b0;
            state_r     <= ST_NORM;
          end else if ((state_r == ST_OUT) && out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= state_r;
          end
        end
        ST_NORM: begin
          if ((man_r == {MAN_W{1'b0}}) || man_r[MAN_W-1] || (cnt_r == MAX_SHIFT)) begin
            state_r <= ST_ROUND;
          end else begin
            man_r <= {man_r[MAN_W-2:0], 1'b0};
            ev_r  <= ev_r - 9'sd1;
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_ROUND: begin
          {out_ovf_r, out_unf_r, out_data_r} <= fp16_round(sign_r, ev_r, man_r);
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_dout_fp16_packer.sv
// Directed bench for fir_dout_fp16_packer: stimulus pushes expected results into a
// scoreboard queue and an independent monitor pops them on every output handshake.
module tb_fir_dout_fp16_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_valid;
  logic        out_ready;

  fir_dout_fp16_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        ovf;
    logic        unf;
    int          rise;
  } exp_t;

  typedef struct {
    logic [28:0] w;
    logic [15:0] d;
    logic        ovf;
    logic        unf;
    int          k;
  } vec_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: tracks the out_valid rising cycle and scores each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) rise_cyc = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_out: got %0h with nothing expected (cycle %0d)", out_data, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", {16'h0, out_data}, {16'h0, e.d});
          chk("out_ovf",  {31'h0, out_ovf},  {31'h0, e.ovf});
          chk("out_unf",  {31'h0, out_unf},  {31'h0, e.unf});
          chk("latency",  rise_cyc,          e.rise);
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit push, output int waited);
    in_data  = v.w;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tot++;
      $display("FAIL accept_timeout: in_ready stayed 0 for word %0h", v.w);
    end else if (push) begin
      sb_q.push_back('{v.d, v.ovf, v.unf, cyc + 1 + 2 + v.k});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 29'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb_q.size(), 0);
  endtask

  vec_t vecs[16] = '{
    '{{1'b0, 6'd31, 22'h200000}, 16'h3C00, 1'b0, 1'b0, 0},
    '{{1'b0, 6'd31, 22'h200400}, 16'h3C00, 1'b0, 1'b0, 0},
    '{{1'b0, 6'd31, 22'h200C00}, 16'h3C02, 1'b0, 1'b0, 0},
    '{{1'b1, 6'd31, 22'h200C00}, 16'hBC02, 1'b0, 1'b0, 0},
    '{{1'b0, 6'd31, 22'h200401}, 16'h3C01, 1'b0, 1'b0, 0},
    '{{1'b0, 6'd31, 22'h100000}, 16'h3800, 1'b0, 1'b0, 1},
    '{{1'b0, 6'd63, 22'h200000}, 16'h7C00, 1'b1, 1'b0, 0},
    '{{1'b0, 6'd46, 22'h3FFFFF}, 16'h7C00, 1'b1, 1'b0, 0},
    '{{1'b0, 6'd46, 22'h200000}, 16'h7800, 1'b0, 1'b0, 0},
    '{{1'b1, 6'd0,  22'h000000}, 16'h8000, 1'b0, 1'b0, 0},
    '{{1'b0, 6'd0,  22'h200000}, 16'h0000, 1'b0, 1'b1, 0},
    '{{1'b0, 6'd17, 22'h200000}, 16'h0400, 1'b0, 1'b0, 0},
    '{{1'b0, 6'd16, 22'h200000}, 16'h0000, 1'b0, 1'b1, 0},
    '{{1'b0, 6'd52, 22'h000003}, 16'h4200, 1'b0, 1'b0, 20},
    '{{1'b1, 6'd20, 22'h000001}, 16'h8000, 1'b0, 1'b1, 21},
    '{{1'b0, 6'd52, 22'h000001}, 16'h3C00, 1'b0, 1'b0, 21}
  };

  initial begin
    int   w;
    int   hi_cnt;
    int   n;
    vec_t v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 29'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
    chk("rst_out_data",  {16'h0, out_data},  32'h0);
    chk("rst_flags",     {30'h0, out_ovf, out_unf}, 32'h0);
    @(posedge clk);
    #1;

    // Back-to-back table traffic with out_ready held high.
    for (int i = 0; i < 16; i++) send(vecs[i], 1'b1, w);
    drain();

    // Long normalisation: in_ready must stay low for the whole NORM phase.
    v = '{{1'b0, 6'd52, 22'h000001}, 16'h3C00, 1'b0, 1'b0, 21};
    send(v, 1'b1, w);
    hi_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (in_ready) hi_cnt++;
    end
    chk("norm_in_ready_low", hi_cnt, 0);
    drain();

    // Backpressure: output held for 5 cycles, then retire and accept in one cycle.
    out_ready = 1'b0;
    v = '{{1'b0, 6'd31, 22'h200C00}, 16'h3C02, 1'b0, 1'b0, 0};
    send(v, 1'b1, w);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_out_data",  {16'h0, out_data},  32'h3C02);
      chk("bp_in_ready",  {31'h0, in_ready},  32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    v = '{{1'b1, 6'd31, 22'h200C00}, 16'hBC02, 1'b0, 1'b0, 0};
    send(v, 1'b1, w);
    chk("b2b_same_cycle_accept", w, 0);
    drain();

    // Reset in NORM drops the word in flight.
    v = '{{1'b0, 6'd52, 22'h000001}, 16'h3C00, 1'b0, 1'b0, 21};
    send(v, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("post_rst_in_ready",  {31'h0, in_ready},  32'h1);
    repeat (40) @(posedge clk);
    #1;
    chk("no_output_after_drop", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_dout_fp16_packer.md
Name: fir_dout_fp16_packer

Overview:
- Return path of the FIR datapath.
- Accepts the FIR's 29-bit wide-float output word (`dout_29i` format) and converts it to IEEE FP16, the same format as the FIR's `din`/`cin`.
- Uses a serial normalise / round-to-nearest-even FSM with valid/ready handshakes on both sides.
- Feeds the FP16 output stream that the host reads back, closing the FP16-in / FP16-out loop.

Parameters:
- MAN_W, 22: input mantissa width, unsigned, not necessarily normalised.
- EXP_W, 6: input exponent width.
- EXP_OFFSET, 52: input value = (-1)^s * M * 2^(E - EXP_OFFSET). Only the defaults are verified.

Ports:
- clk  in  1: single clock. Same clock as the FIR fast clock.
- rst  in  1: synchronous, active-high reset.
- in_data  in  29: [28] sign, [27:22] E, [21:0] M.
- in_valid  in  1: in_data is valid.
- in_ready  out  1: block can accept in_data.
- out_data  out  16: FP16 result.
- out_ovf  out  1: result saturated to ±Inf. Qualified by out_valid.
- out_unf  out  1: nonzero input flushed to ±0. Qualified by out_valid.
- out_valid  out  1: out_data and flags are valid.
- out_ready  in  1: consumer accepts the output.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_data=16'h0000, out_ovf=0, out_unf=0. Any word in flight is dropped and no output is produced for it. rst overrides every other input in that cycle.
- States: IDLE, NORM, ROUND, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready). Combinational.
- Accept (in_valid & in_ready):
  - register s, E, M;
  - ev = E - 16, as a signed 9-bit value;
  - shift counter = 0;
  - next state NORM. This also applies from OUT when out_ready=1: the output retires and the new word is taken in the same cycle.
- OUT with out_ready=1 and no accept → IDLE.
- NORM:
  - if M==0, or M[21]==1 → ROUND;
  - otherwise M <= M<<1, ev <= ev-1, counter++.
  - At most 21 shifts, so the counter is 5 bits.
- ROUND, one cycle; result is registered and the state goes to OUT:
  - M==0 → out_data = {s, 15'h0}, flags 0.
  - ev ≤ 0 before rounding → {s, 15'h0}, out_unf=1. No subnormal outputs.
  - Otherwise: frac = M[20:11], G = M[10], S = |M[9:0]. Round up if G & (S | frac[0]).
  - A carry out of frac gives frac=0 and ev+1.
  - Final ev ≥ 31 → {s, 5'h1F, 10'h0}, out_ovf=1.
  - Otherwise → {s, ev[4:0], frac}.
- OUT:
  - out_valid=1. out_data and flags are held stable until out_ready=1.
  - in_valid is ignored while in_ready=0.
- Latency:
  - the acceptance edge is e0;
  - out_valid is high after edge e0+2+k, where k = leading-zero count of M (0..21);
  - M==0 gives k=0.
- Throughput: one word per 3+k cycles with out_ready held at 1.
- Input E and M are never altered outside the defined shift.
- in_data does not need to be held after acceptance.

Test Plan:
- Normalised input: in_data = {1'b0, 6'd31, 22'h200000}, out_ready=1 → out_data=16'h3C00, flags 0, out_valid high after edge e0+2 for exactly 1 cycle.
- Unnormalised input: {0, 6'd52, 22'h000001} → 16'h3C00 after e0+23. in_ready stays 0 through NORM.
- RNE on a tie:
  - M=22'h200400, E=31 → 16'h3C00 (tie, even, round down);
  - M=22'h200C00 → 16'h3C02;
  - the same word with sign=1 → 16'hBC02.
- Overflow:
  - E=63, M=22'h200000 → 16'h7C00, out_ovf=1;
  - E=46, M=22'h3FFFFF → rounding carry → 16'h7C00, out_ovf=1.
- Zero and underflow:
  - {1, 6'd0, 22'h0} → 16'h8000, flags 0;
  - {0, 6'd0, 22'h200000} → 16'h0000, out_unf=1.
- Backpressure, back-to-back traffic, and reset:
  - hold out_ready=0 for 5 cycles in OUT → out_data stable and in_ready=0;
  - raise out_ready with in_valid=1 → new word accepted in the same cycle;
  - assert rst in NORM → next cycle out_valid=0 and in_ready=1, and no output is emitted for the dropped word.
